divu_sequencer: RTL and testbench

Control and writeback stage wrapped around the iterative unsigned divider.
- Accepts a divide request (operands plus a start pulse).
- Drives the divider's dataA/dataB/Signal/reset inputs through the load, iterate and output phases.
- Captures the divider's 64-bit {quotient, remainder} result into HI/LO registers.
- Signals completion to the issuing pipeline stage.

---
 rtl/divu_sequencer_if.sv | 17 +
 rtl/divu_sequencer.sv | 139 +++++++++++++
 tb/tb_divu_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/divu_sequencer_if.sv
// Issue-side bundle between a pipeline stage and divu_sequencer: request operands,
// status and the captured HI/LO result.
interface divu_sequencer_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  modport master (output start, op_a, op_b,
                  input  busy, done, hi, lo, div_zero);
  modport slave  (input  start, op_a, op_b,
                  output busy, done, hi, lo, div_zero);
endinterface

// File: rtl/divu_sequencer.sv
// Sequences the iterative unsigned divider (load/iterate/output) and captures its
// result into HI/LO. Optional divide-by-zero shortcut: DIVU_ZERO_FASTPATH_EN.
//
// state  | meaning
// IDLE   | waiting for start; operands registered on accept
// LOAD   | divider held in reset for one cycle
// ITER   | SIG_DIVU for ITERATIONS cycles
// OUT    | SIG_OUT; divider latches its result
// CAPT   | result visible on div_dataOut, captured into hi/lo
// ZERO   | (fast path only) divisor zero, result synthesised without the divider
module divu_sequencer #(
  parameter int          ITERATIONS = 33,
  parameter logic [5:0]  SIG_DIVU   = 6'b011011,
  parameter logic [5:0]  SIG_OUT    = 6'b111111,
  parameter logic [5:0]  SIG_IDLE   = 6'b000000
) (
  input  logic               clk,
  input  logic               reset,
  divu_sequencer_if.slave    req,
  output logic [31:0]        div_dataA,
  output logic [31:0]        div_dataB,
  output logic [5:0]         div_signal,
  output logic               div_reset,
  input  logic [63:0]        div_dataOut
);

  localparam int              CW       = $clog2(ITERATIONS + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(ITERATIONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_OUT,
    S_CAPT
`ifdef DIVU_ZERO_FASTPATH_EN
    , S_ZERO
`endif
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          done_q;
  logic [31:0]   hi_q, lo_q;
  logic          accept;

  assign accept = (state == S_IDLE) && req.start;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    div_signal = SIG_IDLE;
    case (state)
      S_IDLE: begin
        if (req.start) begin
`ifdef DIVU_ZERO_FASTPATH_EN
          state_nxt = (req.op_b == 32'd0) ? S_ZERO : S_LOAD;
`else
          state_nxt = S_LOAD;
`endif
        end
      end
      S_LOAD: state_nxt = S_ITER;
      S_ITER: begin
        div_signal = SIG_DIVU;
        if (cnt == CNT_LAST) state_nxt = S_OUT;
      end
      S_OUT: begin
        div_signal = SIG_OUT;
        state_nxt  = S_CAPT;
      end
      S_CAPT: state_nxt = S_IDLE;
`ifdef DIVU_ZERO_FASTPATH_EN
      S_ZERO: state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counter sits at zero outside ITER, so each ITER phase starts from zero.
  always_ff @(posedge clk) begin
    if (reset)                 cnt <= '0;
    else if (state == S_ITER)  cnt <= cnt + 1'b1;
    else                       cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_dataA <= '0;
      div_dataB <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        div_dataA <= req.op_a;
        div_dataB <= req.op_b;
      end
      if (state == S_CAPT) begin
        lo_q   <= div_dataOut[63:32];
        hi_q   <= div_dataOut[31:0];
        done_q <= 1'b1;
      end
`ifdef DIVU_ZERO_FASTPATH_EN
      if (state == S_ZERO) begin
        lo_q   <= 32'hFFFF_FFFF;
        hi_q   <= div_dataA;
        done_q <= 1'b1;
      end
`endif
    end
  end

`ifdef DIVU_ZERO_FASTPATH_EN
  logic zero_q;

  always_ff @(posedge clk) begin
    if (reset)                 zero_q <= 1'b0;
    else if (accept)           zero_q <= 1'b0;
    else if (state == S_ZERO)  zero_q <= 1'b1;
  end

  assign req.div_zero = zero_q;
`else
  assign req.div_zero = 1'b0;
`endif

  assign div_reset = reset | (state == S_LOAD);
  assign req.busy  = (state != S_IDLE);
  assign req.done  = done_q;
  assign req.hi    = hi_q;
  assign req.lo    = lo_q;

endmodule

// File: tb/tb_divu_sequencer.sv
// Bench for divu_sequencer: behavioural divider model on the divider side, scoreboard
// of expected HI/LO/div_zero/latency on the issue side.
module tb_divu_sequencer;
  localparam logic [5:0] SIG_DIVU = 6'b011011;
  localparam logic [5:0] SIG_OUT  = 6'b111111;
  localparam logic [5:0] SIG_IDLE = 6'b000000;
  localparam int         ITER_N   = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] div_dataA, div_dataB;
  logic [5:0]  div_signal;
  logic        div_reset;
  logic [63:0] div_dataOut;

  divu_sequencer_if bus();

  divu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req         (bus),
    .div_dataA   (div_dataA),
    .div_dataB   (div_dataB),
    .div_signal  (div_signal),
    .div_reset   (div_reset),
    .div_dataOut (div_dataOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  int   run    = 0;
  logic prev_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Divider model: result appears the cycle after SIG_OUT.
  always @(posedge clk) begin
    if (div_reset)
      div_dataOut <= 64'd0;
    else if (div_signal == SIG_OUT) begin
      if (div_dataB == 32'd0) div_dataOut <= {32'hFFFF_FFFF, div_dataA};
      else                    div_dataOut <= {div_dataA / div_dataB, div_dataA % div_dataB};
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (div_signal == SIG_DIVU) run++;
    else begin
      if (div_signal == SIG_OUT) check("iter_len", 64'(run), 64'(ITER_N));
      run = 0;
    end
    if (prev_done) check("done_width", {63'd0, bus.done}, 64'd0);
    if (bus.done) begin
      if (sb.size() == 0) check("spurious_done", {63'd0, bus.done}, 64'd0);
      else begin
        e = sb.pop_front();
        check("lo",       {32'd0, bus.lo},       {32'd0, e.lo});
        check("hi",       {32'd0, bus.hi},       {32'd0, e.hi});
        check("div_zero", {63'd0, bus.div_zero}, {63'd0, e.zero});
        check("latency",  64'(cyc - e.t0),       64'(e.lat));
      end
    end
    prev_done = bus.done;
  end

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (b == 32'd0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = a;
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
`ifdef DIVU_ZERO_FASTPATH_EN
    e.zero = (b == 32'd0);
    e.lat  = (b == 32'd0) ? 2 : 37;
`else
    e.zero = 1'b0;
    e.lat  = 37;
`endif
    e.t0 = 0;
    return e;
  endfunction

  // Called at a negedge; drives start for one cycle, scoreboards it if accepted.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic acc;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    acc  = !bus.busy;
    e    = model(a, b);
    e.t0 = cyc;
    if (acc) sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (sb.size() != 0 || bus.busy); i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   {63'd0, bus.busy},      64'd0);
    check({tag, "_done"},   {63'd0, bus.done},      64'd0);
    check({tag, "_hi"},     {32'd0, bus.hi},        64'd0);
    check({tag, "_lo"},     {32'd0, bus.lo},        64'd0);
    check({tag, "_zero"},   {63'd0, bus.div_zero},  64'd0);
    check({tag, "_signal"}, {58'd0, div_signal},    {58'd0, SIG_IDLE});
    check({tag, "_dreset"}, {63'd0, div_reset},     64'd1);
  endtask

  initial begin
    int w;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    check("rst_dataA", {32'd0, div_dataA}, 64'd0);
    check("rst_dataB", {32'd0, div_dataB}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_dreset", {63'd0, div_reset}, 64'd0);

    issue(32'd100, 32'd7);
    check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
    drain();

    issue(32'hFFFF_FFFF, 32'd1);
    drain();
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    drain();
    issue(32'd5, 32'd0);
    drain();

    // Second start while busy must be ignored; hi/lo must hold the old result.
    issue(32'd100, 32'd7);
    repeat (8) @(negedge clk);
    check("hold_hi", {32'd0, bus.hi}, 64'd5);
    check("hold_lo", {32'd0, bus.lo}, 64'hFFFF_FFFF);
    issue(32'd9, 32'd3);
    w = 0;
    while (!bus.done && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("wait_done", {63'd0, bus.done}, 64'd1);
    issue(32'd9, 32'd3);
    drain();

    for (int i = 0; i < 4; i++) begin
      issue($urandom, (i == 3) ? 32'($urandom_range(1, 255)) : $urandom);
      drain();
    end

    // Abort mid-divide.
    issue(32'd1000, 32'd3);
    repeat (18) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check_reset_outputs("abort");
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_idle", {63'd0, bus.busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
